// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults and FSM state encoding for the pattern scanner
package seq_det_pkg;
  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
endpackage

// File: rtl/pattern_match.sv
// pattern_match: serial history register, fill count and masked compare producing a combinational hit
// ports: clk, rst_n (sync active-low), clr (wipe history), shift (sample data), data, pat, len -> hit
module pattern_match #(
  parameter int MAX_LEN = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               shift,
  input  logic               data,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [3:0]         len,
  output logic               hit
);
  localparam logic [3:0] FMAX = 4'(MAX_LEN);
  logic [MAX_LEN-1:0] hist, nxt, mask;
  logic [3:0] fill;
  // hit looks at the history including the bit being sampled this cycle
  always_comb begin
    nxt = {hist[MAX_LEN-2:0], data};
    mask = ~({MAX_LEN{1'b1}} << len);
    hit = shift && (fill >= len - 4'd1) && (((nxt ^ pat) & mask) == '0);
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= nxt;
      fill <= (fill == FMAX) ? fill : fill + 4'd1;
    end
  end
endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: scans a window of valid serial bits for a programmable pattern, counting overlapping matches
// ports: clk, rst_n (sync active-low), start/pat/len/win (scan request), data/data_valid (serial input), abort,
//        busy, detected (match pulse), match_cnt, done (completion pulse), cfg_err (rejected start pulse)
module pattern_scan_ctrl import seq_det_pkg::*; #(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [3:0]         len,
  input  logic [CNT_W-1:0]   win,
  input  logic               data,
  input  logic               data_valid,
  input  logic               abort,
  output logic               busy,
  output logic               detected,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               done,
  output logic               cfg_err
);
  localparam logic [3:0] LMAX = 4'(MAX_LEN);
  state_t state, nxt_state;
  logic [MAX_LEN-1:0] pat_r;
  logic [3:0] len_r;
  logic [CNT_W-1:0] win_r, bit_cnt;
  logic len_ok, shift, last, hit;
  pattern_match #(.MAX_LEN(MAX_LEN)) u_match (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state == LOAD),
    .shift(shift),
    .data(data),
    .pat(pat_r),
    .len(len_r),
    .hit(hit)
  );
  // abort wins over a coincident valid bit, so it simply suppresses the shift
  always_comb begin
    len_ok = len >= 4'd2 && len <= LMAX;
    shift = state == RUN && data_valid && !abort;
    last = (bit_cnt + CNT_W'(1)) == win_r;
    busy = state == LOAD || state == RUN;
    done = state == DONE;
    nxt_state = state;
    case (state)
      IDLE: nxt_state = (start && len_ok) ? LOAD : IDLE;
      LOAD: nxt_state = abort ? IDLE : (win_r == '0) ? DONE : RUN;
      RUN:  nxt_state = abort ? IDLE : (shift && last) ? DONE : RUN;
      DONE: nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt_state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_r <= '0;
      len_r <= '0;
      win_r <= '0;
      bit_cnt <= '0;
      match_cnt <= '0;
      detected <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      detected <= hit;
      cfg_err <= state == IDLE && start && !len_ok;
      if (state == IDLE && start && len_ok) begin
        pat_r <= pat;
        len_r <= len;
        win_r <= win;
      end
      if (state == LOAD) begin
        bit_cnt <= '0;
        match_cnt <= '0;
      end else if (shift) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (hit && !(&match_cnt)) match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 Parameter MAX_LEN, default 8, SHALL set the maximum pattern length in bits.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the window and match counters.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 start  input  1  SHALL request a scan; it is sampled only in IDLE.
REQ-006 pat  input  MAX_LEN  SHALL carry the pattern; pat[len-1] is the first bit expected and pat[0] the last.
REQ-007 len  input  4  SHALL carry the pattern length in bits; the legal range is 2..MAX_LEN.
REQ-008 win  input  CNT_W  SHALL carry the number of valid data bits to observe in the scan.
REQ-009 data  input  1  SHALL carry the serial data bit.
REQ-010 data_valid  input  1  SHALL qualify data; a bit is sampled only when data_valid=1.
REQ-011 abort  input  1  SHALL terminate a running scan.
REQ-012 busy  output  1  SHALL be 1 in the LOAD and RUN states.
REQ-013 detected  output  1  SHALL be a registered one-cycle pulse per pattern match.
REQ-014 match_cnt  output  CNT_W  SHALL give the number of matches found in the current or last scan.
REQ-015 done  output  1  SHALL be a one-cycle pulse marking normal completion of a scan.
REQ-016 cfg_err  output  1  SHALL be a one-cycle pulse marking a rejected start.

Function
REQ-017 The FSM SHALL have four states: IDLE, LOAD, RUN and DONE.
REQ-018 IDLE with start=1 and 2<=len<=MAX_LEN SHALL latch pat, len and win, and go to LOAD.
REQ-019 IDLE with start=1 and len outside 2..MAX_LEN SHALL pulse cfg_err on the next cycle and remain in IDLE; match_cnt SHALL be unchanged.
REQ-020 LOAD SHALL clear the shift history, the fill count, the bit counter and match_cnt, then go to RUN, or to DONE if win==0.
REQ-021 In RUN, each data_valid=1 cycle SHALL shift data into the history and increment the bit counter.
REQ-022 A match SHALL occur when the fill count is >=len and the last len sampled bits equal pat[len-1:0]; overlapping matches SHALL be counted.
REQ-023 On a match, detected SHALL be 1 in the cycle after the sampling cycle (Moore-style), and match_cnt SHALL increment on the same edge.
REQ-024 match_cnt SHALL saturate at 2^CNT_W-1.
REQ-025 When the bit counter reaches win, RUN SHALL go to DONE; done SHALL be 1 in the cycle after the final bit was sampled, coincident with any detected pulse for that bit.
REQ-026 DONE SHALL last one cycle and then go to IDLE.
REQ-027 match_cnt SHALL hold its value until the next accepted start.
REQ-028 start in LOAD, RUN or DONE SHALL be ignored.
REQ-029 data_valid=0 cycles SHALL neither shift the history nor count toward win, and SHALL NOT break a partial match.
REQ-030 abort=1 in LOAD or RUN SHALL force IDLE on the next edge with no done pulse.
REQ-031 If abort is asserted in the same cycle as a valid bit, abort SHALL take priority: that bit is discarded and match_cnt keeps its pre-abort value.
REQ-032 abort in IDLE or DONE SHALL have no effect.

Reset
REQ-033 rst_n=0 at a clock edge SHALL force IDLE, busy=0, detected=0, done=0, cfg_err=0, match_cnt=0, and clear the history and all counters, including in the middle of a scan.

Structure
REQ-034 A shared package seq_det_pkg SHALL hold the MAX_LEN and CNT_W defaults and the state enum {IDLE, LOAD, RUN, DONE}.
REQ-035 One sub-module, pattern_match, SHALL hold the history shift register, the fill count and the masked compare, and output a combinational hit.

Verification
REQ-036 pat=0x13, len=5, win=10, data 1,0,0,1,1,0,0,1,1,1 all valid -> detected after bits 5 and 9, match_cnt=2, done the cycle after bit 10.
REQ-037 pat=0x0F, len=4, win=7, seven 1s with data_valid toggling 1,0 -> 4 detected pulses, match_cnt=4, done after the 7th valid bit.
REQ-038 start with len=1, and separately with len=9 -> cfg_err pulse in each case, busy stays 0, match_cnt unchanged.
REQ-039 win=0 with a valid start -> sequence LOAD, DONE, with done one cycle after LOAD and match_cnt=0.
REQ-040 Abort applied coincident with bit 5 of the REQ-036 stream -> no detected pulse, no done, match_cnt=0, IDLE next cycle.
REQ-041 rst_n=0 after bit 6 of the REQ-036 stream -> all outputs 0 next cycle; a new start then yields match_cnt=2 again.
